// File: rtl/systolic_ctrl_if.sv
// Scheduler-side job handshake for systolic_ctrl.
// The tile scheduler drives the job request (master). The controller
// reports busy and the one-cycle done pulse (slave).
interface systolic_ctrl_if #(
  parameter int K_MAX = 16,
  parameter int KW    = $clog2(K_MAX + 1)
) ();
  logic          start_i;
  logic          load_w_i;
  logic          acc_i;
  logic [KW-1:0] k_i;
  logic          busy_o;
  logic          done_o;

  modport master (
    output start_i, load_w_i, acc_i, k_i,
    input  busy_o, done_o
  );

  modport slave (
    input  start_i, load_w_i, acc_i, k_i,
    output busy_o, done_o
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencing controller for a ROWS x COLS weight-stationary systolic array.
// It loads the stationary weights bottom row first, then streams k skewed
// activation vectors. It flags the bottom-edge result cycles per column.
// The block holds control only; all outputs are Moore decodes of the
// registered state and counters.
module systolic_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 16,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = $clog2(K_MAX + ROWS + COLS + 1),
  localparam int MUX_W = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  systolic_ctrl_if.slave          sched,
  output logic [ROWS*MUX_W-1:0]   mux_o,
  output logic [ROWS-1:0]         add_zero_o,
  output logic                    w_valid_o,
  output logic [ROW_W-1:0]        w_row_o,
  output logic [ROWS-1:0]         act_valid_o,
  output logic [COLS-1:0]         out_valid_o
);

  typedef enum logic [MUX_W-1:0] {
    MUX_PASSTHROUGH = 2'd0,
    MUX_LOAD        = 2'd1,
    MUX_PROCESS     = 2'd2
  } input_mux_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_W  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [ROW_W-1:0] r_wc;
  logic [CW-1:0]    r_cc;
  logic [KW-1:0]    r_k;
  logic             r_acc;

  state_t           w_state_nxt;
  logic [ROW_W-1:0] w_wc_nxt;
  logic [CW-1:0]    w_cc_nxt;
  logic             w_latch;
  logic [KW-1:0]    w_k_clamp;
  logic [CW-1:0]    w_cc_last;
  logic             w_wc_last;

  // Clamp the requested vector count to K_MAX at the point of latching.
  assign w_k_clamp = (sched.k_i > KW'(K_MAX)) ? KW'(K_MAX) : sched.k_i;
  // COMPUTE runs k+ROWS+COLS-1 cycles, so the last counter value is k+ROWS+COLS-2.
  assign w_cc_last = CW'(r_k) + CW'(ROWS + COLS - 2);
  assign w_wc_last = (r_wc == ROW_W'(ROWS - 1));

  // State, counters and latched job parameters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_wc    <= '0;
      r_cc    <= '0;
      r_k     <= '0;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wc    <= w_wc_nxt;
      r_cc    <= w_cc_nxt;
      if (w_latch) begin
        r_k   <= w_k_clamp;
        r_acc <= sched.acc_i;
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_wc_nxt     = r_wc;
    w_cc_nxt     = r_cc;
    w_latch      = 1'b0;
    sched.busy_o = 1'b0;
    sched.done_o = 1'b0;
    mux_o        = {ROWS{MUX_PASSTHROUGH}};
    add_zero_o   = '0;
    w_valid_o    = 1'b0;
    w_row_o      = '0;
    act_valid_o  = '0;
    out_valid_o  = '0;

    case (r_state)
      S_IDLE: begin
        w_wc_nxt = '0;
        w_cc_nxt = '0;
        if (sched.start_i) begin
          w_latch = 1'b1;
          if (sched.load_w_i)       w_state_nxt = S_LOAD_W;
          else if (w_k_clamp != '0) w_state_nxt = S_COMPUTE;
          else                      w_state_nxt = S_DONE;
        end
      end

      S_LOAD_W: begin
        sched.busy_o = 1'b1;
        w_valid_o    = 1'b1;
        // The bottom row's weights go in first. They ripple down through
        // PASSTHROUGH rows until the final LOAD cycle latches every row at once.
        w_row_o      = ROW_W'(ROWS - 1) - r_wc;
        if (w_wc_last) begin
          mux_o       = {ROWS{MUX_LOAD}};
          w_wc_nxt    = '0;
          w_state_nxt = (r_k != '0) ? S_COMPUTE : S_DONE;
        end else begin
          w_wc_nxt    = r_wc + ROW_W'(1);
        end
      end

      S_COMPUTE: begin
        sched.busy_o  = 1'b1;
        mux_o         = {ROWS{MUX_PROCESS}};
        add_zero_o[0] = ~r_acc;
        // Window tests use wrapping subtraction. When cc < offset, the
        // difference wraps to at least 2^CW - offset, and that value always
        // exceeds K_MAX. So one unsigned compare covers both window edges.
        for (int r = 0; r < ROWS; r++) begin
          act_valid_o[r] = (r_cc - CW'(r)) < CW'(r_k);
        end
        for (int c = 0; c < COLS; c++) begin
          out_valid_o[c] = (r_cc - CW'(c + ROWS)) < CW'(r_k);
        end
        if (r_cc == w_cc_last) begin
          w_cc_nxt    = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cc_nxt    = r_cc + CW'(1);
        end
      end

      S_DONE: begin
        sched.done_o = 1'b1;
        w_state_nxt  = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

- Sequencing controller for a ROWS x COLS weight-stationary systolic array of `pe` tiles.
- Drives each row's `input_mux_t` mux and `add_zero` control, and paces the external weight and activation feeders.
- Flags the cycles in which each column's bottom-edge result is valid.
- Sits between the tile scheduler (start/done handshake) and the PE grid; holds no datapath.

## Interface
Parameters:
- ROWS, 4, PE rows (>=1)
- COLS, 4, PE columns (>=1)
- K_MAX, 16, max activation vectors per job; KW = $clog2(K_MAX+1)

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  job request; sampled only in IDLE
- load_w_i  in  1  with start_i: 1 = reload stationary weights first, 0 = reuse loaded weights
- acc_i  in  1  with start_i: 1 = row 0 accumulates its top_i (K-tiling), 0 = row 0 adds zero
- k_i  in  KW  with start_i: number of activation vectors, 0..K_MAX
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse
- mux_o  out  ROWS*$bits(input_mux_t)  per-row mux select, row r at slice r; enum from pkg.v
- add_zero_o  out  ROWS  per-row add_zero
- w_valid_o  out  1  weight feeder must present a weight row at the top edge this cycle
- w_row_o  out  $clog2(ROWS) (min 1)  index of the PE row whose weights are presented
- act_valid_o  out  ROWS  row r activation feeder must present the next element at the left edge this cycle
- out_valid_o  out  COLS  column c bottom_o of the last row holds a valid result this cycle

## Operation
- FSM states: IDLE, LOAD_W, COMPUTE, DONE. All outputs are Moore, decoded from registered state and counters.
- Reset values: state IDLE, counters 0, busy_o=0, done_o=0, all mux_o=PASSTHROUGH, add_zero_o=0, w_valid_o=0, w_row_o=0, act_valid_o=0, out_valid_o=0.
- IDLE:
  - mux_o = PASSTHROUGH on all rows.
  - On start_i, latch k_i, acc_i and load_w_i.
  - Next state is LOAD_W if load_w_i=1; else COMPUTE if k>0; else DONE.
- LOAD_W: ROWS cycles, counter wc = 0..ROWS-1.
  - w_valid_o=1 and w_row_o = ROWS-1-wc, so the bottom row's weights are fed first.
  - mux_o = PASSTHROUGH on all rows while wc<ROWS-1; mux_o = LOAD on all rows when wc=ROWS-1.
  - Exit: to COMPUTE if k>0, else DONE.
  - ROWS=1: a single LOAD cycle.
- COMPUTE: N = k+ROWS+COLS-1 cycles, counter cc = 0..N-1.
  - mux_o = PROCESS on all rows.
  - add_zero_o[0] = ~acc latched; add_zero_o[r>0] = 0.
  - act_valid_o[r]=1 for r <= cc <= r+k-1 (skew); the feeder drives vector j's row-r element at cc=j+r.
  - out_valid_o[c]=1 for c+ROWS <= cc <= c+ROWS+k-1; vector j's column-c result appears at cc=j+c+ROWS.
  - After cc=N-1, go to DONE.
- DONE: one cycle, done_o=1, mux_o=PASSTHROUGH. Returns to IDLE.
- busy_o = 1 in LOAD_W and COMPUTE; 0 in IDLE and DONE.
- start_i outside IDLE is ignored. It is not queued; no error.
- k_i > K_MAX is clamped to K_MAX at latch.
- add_zero_o is 0 outside COMPUTE.
- Counter widths must hold K_MAX+ROWS+COLS-1 without wrap.
- rst_i asserted in any state returns to IDLE with the reset values on the next edge. A partially loaded array is not cleaned up; the next job must use load_w_i=1.

## Timing
- start_i high in IDLE at cycle T, with load_w_i=1 and k>0:
  - LOAD_W occupies T+1..T+ROWS.
  - COMPUTE occupies T+ROWS+1..T+2ROWS+k+COLS-1.
  - done_o is high at T+2ROWS+k+COLS.
  - IDLE at T+2ROWS+k+COLS+1; a new start is accepted that cycle.
- With load_w_i=0, remove the ROWS-cycle LOAD_W term.
- k=0 with load_w_i=0: done_o at T+1, busy_o never asserts.
- Row r PE latches its weight at the edge ending wc=ROWS-1. Its top_i then carries the weight fed at wc=ROWS-1-r.
- Back-to-back jobs have a minimum of 1 IDLE cycle between done_o and the next busy_o.

## Test plan
- ROWS=COLS=4, start with load_w_i=1, k=3, acc=0:
  - w_row_o sequence 3,2,1,0, with LOAD only on the 4th cycle.
  - COMPUTE lasts 10 cycles; act_valid_o[2] is high at cc=2..4; out_valid_o[3] is high at cc=7..9.
  - done_o at T+15; a PE-grid model with identity weights returns the activations unchanged.
- Same array, load_w_i=0, k=1, acc=1:
  - No w_valid_o.
  - add_zero_o=4'b0000 during COMPUTE.
  - Bottom result equals top partial sum + product.
- k=0 with load_w_i=1 -> 4 LOAD_W cycles, then done_o; act_valid_o and out_valid_o never assert. k=0 with load_w_i=0 -> done_o the cycle after start.
- start_i held high continuously with k=16 (K_MAX):
  - Jobs repeat with exactly 1 IDLE cycle between them; pulses during busy are ignored.
  - k_i=31 clamps to 16.
- rst_i pulsed at cc=5 of COMPUTE -> the next cycle shows IDLE, all mux_o=PASSTHROUGH, busy_o=0, and no done_o.
- ROWS=1, COLS=1, load_w_i=1, k=2 -> a single LOAD cycle; COMPUTE lasts 3 cycles; out_valid_o high at cc=1..2.
